// File: rtl/conv_engine_if.sv
// Bundle of the layer-sequencer controls and the shared DRAM port seen by conv_engine.
// master = the convolution engine, slave = sequencer/memory side.
interface conv_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int DIM_WIDTH  = 8,
    parameter int CHNL_WIDTH = 5
);
    logic                  start;
    logic [DIM_WIDTH-1:0]  cfg_w;
    logic [DIM_WIDTH-1:0]  cfg_h;
    logic [2:0]            cfg_k;
    logic [1:0]            cfg_stride;
    logic [CHNL_WIDTH-1:0] cfg_ic;
    logic [CHNL_WIDTH-1:0] cfg_oc;
    logic                  cfg_relu;
    logic [ADDR_WIDTH-1:0] cfg_ifmap_base;
    logic [ADDR_WIDTH-1:0] cfg_wgt_base;
    logic [ADDR_WIDTH-1:0] cfg_bias_base;
    logic [ADDR_WIDTH-1:0] cfg_ofmap_base;
    logic                  dram_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  dram_en_rd;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic                  dram_en_wr;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  start, cfg_w, cfg_h, cfg_k, cfg_stride, cfg_ic, cfg_oc, cfg_relu,
               cfg_ifmap_base, cfg_wgt_base, cfg_bias_base, cfg_ofmap_base,
               dram_valid, data_in,
        output dram_en_rd, addr_in, dram_en_wr, addr_out, data_out, busy, done, err
    );

    modport slave (
        output start, cfg_w, cfg_h, cfg_k, cfg_stride, cfg_ic, cfg_oc, cfg_relu,
               cfg_ifmap_base, cfg_wgt_base, cfg_bias_base, cfg_ofmap_base,
               dram_valid, data_in,
        input  dram_en_rd, addr_in, dram_en_wr, addr_out, data_out, busy, done, err
    );
endinterface

// File: rtl/conv_engine.sv
// Multi-channel fixed-point convolution layer engine: streams bias, weights and ifmap
// words from DRAM one read at a time, accumulates per output pixel and writes results back.
module conv_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int FRAC_BITS  = 16,
    parameter int KNL_MAX    = 5,
    parameter int CHNL_MAX   = 16,
    parameter int DIM_WIDTH  = 8,
    parameter int CHNL_WIDTH = 5
) (
    input  logic         clk,
    input  logic         srstn,
    conv_engine_if.master bus,
    output logic [2:0]   dbg_state
);
    localparam int AW     = 2*DATA_WIDTH + 8;
    localparam int WBUF_D = CHNL_MAX*KNL_MAX*KNL_MAX;
    localparam int TAP_W  = $clog2(WBUF_D + 1);
    localparam int PW     = 2*DIM_WIDTH;

    typedef enum logic [2:0] {IDLE, CHECK, LD_BIAS, LD_WGT, MAC, WRITE, FIN} state_t;
    state_t state;

    logic [DIM_WIDTH-1:0]         w_q, h_q, x0, y0;
    logic [2:0]                   k_q, kx, ky;
    logic [1:0]                   s_q;
    logic [CHNL_WIDTH-1:0]        ic_q, oc_q, ic_cnt, oc_cnt;
    logic                         relu_q;
    logic [ADDR_WIDTH-1:0]        ifm_base_q, bias_base_q, wgt_ptr, ofm_ptr, ifm_addr;
    logic [PW-1:0]                plane;
    logic [TAP_W-1:0]             taps, tap;
    logic signed [AW-1:0]         acc, acc_next, prod_x, bias_x, biased, shifted;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0] bias_q;
    logic signed [DATA_WIDTH-1:0] wbuf [WBUF_D];
    logic [DATA_WIDTH-1:0]        result;
    logic [31:0]                  ifm_off;
    logic                         cfg_bad, last_tap, x_more, y_more, last_oc;

    assign dbg_state = state;

    always_comb begin
        cfg_bad  = (k_q == 3'd0) || (32'(k_q) > KNL_MAX) || (s_q == 2'd0) ||
                   (ic_q == '0) || (32'(ic_q) > CHNL_MAX) || (oc_q == '0) ||
                   (DIM_WIDTH'(k_q) > w_q) || (DIM_WIDTH'(k_q) > h_q);
        last_tap = (tap == taps - TAP_W'(1));
        x_more   = (32'(x0) + 32'(s_q) + 32'(k_q)) <= 32'(w_q);
        y_more   = (32'(y0) + 32'(s_q) + 32'(k_q)) <= 32'(h_q);
        last_oc  = (oc_cnt + CHNL_WIDTH'(1)) == oc_q;
        ifm_off  = 32'(ic_cnt) * 32'(plane) + (32'(y0) + 32'(ky)) * 32'(w_q)
                 + 32'(x0) + 32'(kx);
        ifm_addr = ifm_base_q + ADDR_WIDTH'(ifm_off);
    end

    // Full-precision MAC, bias aligned to the product scale, floor shift, then clamp.
    always_comb begin
        prod     = $signed(bus.data_in) * wbuf[tap];
        prod_x   = {{(AW-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
        acc_next = acc + prod_x;
        bias_x   = {{(AW-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
        biased   = acc_next + (bias_x <<< FRAC_BITS);
        shifted  = biased >>> FRAC_BITS;
        if ((shifted[AW-1:DATA_WIDTH-1] == '0) || (shifted[AW-1:DATA_WIDTH-1] == '1))
            result = shifted[DATA_WIDTH-1:0];
        else if (shifted[AW-1])
            result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        if (relu_q && result[DATA_WIDTH-1])
            result = '0;
    end

    always_ff @(posedge clk) begin
        if (state == LD_WGT && bus.dram_en_rd && bus.dram_valid)
            wbuf[tap] <= $signed(bus.data_in);
    end

    // Read handshake: dram_en_rd is raised one cycle after entering a read state with
    // addr_in held; a word transfers on any edge where dram_en_rd && dram_valid, after
    // which dram_en_rd drops for one cycle, so at most one read is ever outstanding.
    always_ff @(posedge clk) begin
        if (srstn) begin
            state          <= IDLE;
            bus.dram_en_rd <= 1'b0;
            bus.addr_in    <= '0;
            bus.dram_en_wr <= 1'b0;
            bus.addr_out   <= '0;
            bus.data_out   <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            w_q <= '0;  h_q <= '0;  k_q <= '0;  s_q <= '0;
            ic_q <= '0; oc_q <= '0; relu_q <= 1'b0;
            ifm_base_q <= '0; bias_base_q <= '0; wgt_ptr <= '0; ofm_ptr <= '0;
            plane <= '0; taps <= '0; tap <= '0;
            kx <= '0; ky <= '0; ic_cnt <= '0; oc_cnt <= '0; x0 <= '0; y0 <= '0;
            acc <= '0; bias_q <= '0;
        end else begin
            bus.done       <= 1'b0;
            bus.dram_en_wr <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    w_q         <= bus.cfg_w;
                    h_q         <= bus.cfg_h;
                    k_q         <= bus.cfg_k;
                    s_q         <= bus.cfg_stride;
                    ic_q        <= bus.cfg_ic;
                    oc_q        <= bus.cfg_oc;
                    relu_q      <= bus.cfg_relu;
                    ifm_base_q  <= bus.cfg_ifmap_base;
                    bias_base_q <= bus.cfg_bias_base;
                    wgt_ptr     <= bus.cfg_wgt_base;
                    ofm_ptr     <= bus.cfg_ofmap_base;
                    bus.busy    <= 1'b1;
                    bus.err     <= 1'b0;
                    state       <= CHECK;
                end
                CHECK: begin
                    plane  <= PW'(32'(w_q) * 32'(h_q));
                    taps   <= TAP_W'(32'(ic_q) * 32'(k_q) * 32'(k_q));
                    tap    <= '0;
                    kx     <= '0;
                    ky     <= '0;
                    ic_cnt <= '0;
                    oc_cnt <= '0;
                    x0     <= '0;
                    y0     <= '0;
                    acc    <= '0;
                    if (cfg_bad) begin
                        bus.err  <= 1'b1;
                        bus.done <= 1'b1;
                        state    <= FIN;
                    end else begin
                        state <= LD_BIAS;
                    end
                end
                LD_BIAS: if (!bus.dram_en_rd) begin
                    bus.dram_en_rd <= 1'b1;
                    bus.addr_in    <= bias_base_q + ADDR_WIDTH'(oc_cnt);
                end else if (bus.dram_valid) begin
                    bus.dram_en_rd <= 1'b0;
                    bias_q         <= $signed(bus.data_in);
                    tap            <= '0;
                    state          <= LD_WGT;
                end
                LD_WGT: if (!bus.dram_en_rd) begin
                    bus.dram_en_rd <= 1'b1;
                    bus.addr_in    <= wgt_ptr;
                end else if (bus.dram_valid) begin
                    bus.dram_en_rd <= 1'b0;
                    wgt_ptr        <= wgt_ptr + ADDR_WIDTH'(1);
                    if (last_tap) begin
                        tap   <= '0;
                        state <= MAC;
                    end else begin
                        tap <= tap + TAP_W'(1);
                    end
                end
                MAC: if (!bus.dram_en_rd) begin
                    bus.dram_en_rd <= 1'b1;
                    bus.addr_in    <= ifm_addr;
                end else if (bus.dram_valid) begin
                    bus.dram_en_rd <= 1'b0;
                    acc            <= acc_next;
                    if (last_tap) begin
                        tap            <= '0;
                        kx             <= '0;
                        ky             <= '0;
                        ic_cnt         <= '0;
                        bus.addr_out   <= ofm_ptr;
                        bus.data_out   <= result;
                        bus.dram_en_wr <= 1'b1;
                        state          <= WRITE;
                    end else begin
                        tap <= tap + TAP_W'(1);
                        if (kx == k_q - 3'd1) begin
                            kx <= '0;
                            if (ky == k_q - 3'd1) begin
                                ky     <= '0;
                                ic_cnt <= ic_cnt + CHNL_WIDTH'(1);
                            end else begin
                                ky <= ky + 3'd1;
                            end
                        end else begin
                            kx <= kx + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    acc     <= '0;
                    ofm_ptr <= ofm_ptr + ADDR_WIDTH'(1);
                    if (x_more) begin
                        x0 <= x0 + DIM_WIDTH'(s_q);
                    end else begin
                        x0 <= '0;
                        y0 <= y_more ? y0 + DIM_WIDTH'(s_q) : '0;
                    end
                    if (x_more || y_more) begin
                        state <= MAC;
                    end else if (last_oc) begin
                        bus.done <= 1'b1;
                        state    <= FIN;
                    end else begin
                        oc_cnt <= oc_cnt + CHNL_WIDTH'(1);
                        state  <= LD_BIAS;
                    end
                end
                FIN: begin
                    bus.busy <= 1'b0;
                    bus.err  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_engine.sv
// Directed bench for conv_engine: behavioural DRAM with programmable read latency,
// expected-write queue, hand-computed results for each layer configuration.
module tb_conv_engine;
    localparam int DW = 32;
    localparam int AW = 18;

    logic        clk = 1'b0;
    logic        srstn;
    logic [2:0]  dbg_state;
    int          checks = 0;
    int          errors = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [31:0] mem [0:1023];
    int          fixed_lat = 0;
    bit          rand_lat = 1'b0;
    int          rd_cycles = 0;
    int          rd_acc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;

    conv_engine_if bus();
    conv_engine dut (.clk(clk), .srstn(srstn), .bus(bus), .dbg_state(dbg_state));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // DRAM model and write monitor, evaluated on the falling edge.
    initial begin
        bit in_req;
        int wait_cnt;
        int cur_lat;
        logic [AW+DW-1:0] exp_w;
        in_req = 1'b0;
        wait_cnt = 0;
        cur_lat = 0;
        forever begin
            @(negedge clk);
            if (bus.dram_en_rd === 1'b1) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wait_cnt = 0;
                    cur_lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
                end
                rd_cycles++;
                if (wait_cnt >= cur_lat) begin
                    bus.dram_valid = 1'b1;
                    bus.data_in = mem[bus.addr_in[9:0]];
                    rd_acc++;
                end else begin
                    bus.dram_valid = 1'b0;
                    wait_cnt++;
                end
            end else begin
                in_req = 1'b0;
                bus.dram_valid = 1'b0;
            end
            if (bus.dram_en_wr === 1'b1) begin
                wr_cnt++;
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check("write_addr_data", 64'({bus.addr_out, bus.data_out}), 64'(exp_w));
                end
            end
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic fill(input int base, input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) mem[base + i] = v;
    endtask

    task automatic expect_wr(input int a, input logic [31:0] d);
        exp_q.push_back({AW'(a), d});
    endtask

    task automatic set_cfg(input int w, input int h, input int k, input int s,
                           input int ic, input int oc, input bit relu);
        bus.cfg_w      = 8'(w);
        bus.cfg_h      = 8'(h);
        bus.cfg_k      = 3'(k);
        bus.cfg_stride = 2'(s);
        bus.cfg_ic     = 5'(ic);
        bus.cfg_oc     = 5'(oc);
        bus.cfg_relu   = relu;
    endtask

    task automatic run_conv(input string tag, output int cyc);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
        @(negedge clk);
        check({tag, "_all_writes_seen"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_idle"}, 64'({bus.busy, bus.done}), 64'd0);
    endtask

    task automatic err_case(input string tag);
        int base_rd;
        int base_wr;
        base_rd = rd_cycles;
        base_wr = wr_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_cyc1_busy_done_err"}, 64'({bus.busy, bus.done, bus.err}), 64'b100);
        @(negedge clk);
        check({tag, "_cyc2_busy_done_err"}, 64'({bus.busy, bus.done, bus.err}), 64'b111);
        @(negedge clk);
        check({tag, "_cyc3_busy_done_err"}, 64'({bus.busy, bus.done, bus.err}), 64'b000);
        check({tag, "_no_reads"}, 64'(rd_cycles - base_rd), 64'd0);
        check({tag, "_no_writes"}, 64'(wr_cnt - base_wr), 64'd0);
    endtask

    task automatic load_t1();
        fill(0, 16, 32'h0001_0000);
        fill(32'h100, 9, 32'h0001_0000);
        mem[32'h200] = 32'h0;
    endtask

    initial begin
        int cyc;
        int n;
        int base_done;
        int base_wr;
        int base_acc;
        srstn = 1'b1;
        bus.start = 1'b0;
        bus.dram_valid = 1'b0;
        bus.data_in = '0;
        bus.cfg_ifmap_base = 18'h000;
        bus.cfg_wgt_base   = 18'h100;
        bus.cfg_bias_base  = 18'h200;
        bus.cfg_ofmap_base = 18'h300;
        set_cfg(4, 4, 3, 1, 1, 1, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_en_rd", 64'(bus.dram_en_rd), 64'd0);
        check("rst_en_wr", 64'(bus.dram_en_wr), 64'd0);
        check("rst_busy_done_err", 64'({bus.busy, bus.done, bus.err}), 64'd0);
        check("rst_addr_in", 64'(bus.addr_in), 64'd0);
        check("rst_addr_data_out", 64'({bus.addr_out, bus.data_out}), 64'd0);
        srstn = 1'b0;

        // 4x4 ifmap of 1.0, 3x3 kernel of 1.0: four outputs of 9.0, zero-latency memory.
        load_t1();
        for (int i = 0; i < 4; i++) expect_wr(32'h300 + i, 32'h0009_0000);
        fixed_lat = 0;
        run_conv("t1", cyc);
        check("t1_cycles", 64'(cyc), 64'd97);

        // 5x5, K=3, S=2, two channels in/out; ramp ifmap; oc1 bias 1.0.
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 25; p++) mem[c*25 + p] = 32'(p) << 16;
        fill(32'h100, 36, 32'h0001_0000);
        mem[32'h200] = 32'h0;
        mem[32'h201] = 32'h0001_0000;
        expect_wr(32'h300, 32'h006C_0000);
        expect_wr(32'h301, 32'h0090_0000);
        expect_wr(32'h302, 32'h0120_0000);
        expect_wr(32'h303, 32'h0144_0000);
        expect_wr(32'h304, 32'h006D_0000);
        expect_wr(32'h305, 32'h0091_0000);
        expect_wr(32'h306, 32'h0121_0000);
        expect_wr(32'h307, 32'h0145_0000);
        set_cfg(5, 5, 3, 2, 2, 2, 1'b0);
        fixed_lat = 1;
        run_conv("t2", cyc);

        // Negative weights: -9.0 without ReLU, 0 with ReLU.
        fill(0, 9, 32'h0001_0000);
        fill(32'h100, 9, 32'hFFFF_0000);
        mem[32'h200] = 32'h0;
        fixed_lat = 2;
        set_cfg(3, 3, 3, 1, 1, 1, 1'b0);
        expect_wr(32'h300, 32'hFFF7_0000);
        run_conv("t3_norelu", cyc);
        set_cfg(3, 3, 3, 1, 1, 1, 1'b1);
        expect_wr(32'h300, 32'h0000_0000);
        run_conv("t3_relu", cyc);

        // Saturation at both rails with a full 5x5 kernel.
        fill(0, 25, 32'h7FFF_0000);
        fill(32'h100, 25, 32'h7FFF_0000);
        fixed_lat = 0;
        set_cfg(5, 5, 5, 1, 1, 1, 1'b0);
        expect_wr(32'h300, 32'h7FFF_FFFF);
        run_conv("t4_pos_sat", cyc);
        fill(32'h100, 25, 32'h8001_0000);
        expect_wr(32'h300, 32'h8000_0000);
        run_conv("t4_neg_sat", cyc);

        // Rejected configurations.
        set_cfg(8, 8, 6, 1, 1, 1, 1'b0);
        err_case("err_k6");
        set_cfg(8, 8, 3, 0, 1, 1, 1'b0);
        err_case("err_s0");
        set_cfg(8, 8, 3, 1, 17, 1, 1'b0);
        err_case("err_ic17");

        // Abort during MAC with random latency, then a clean rerun of the first layer.
        load_t1();
        rand_lat = 1'b1;
        set_cfg(4, 4, 3, 1, 1, 1, 1'b0);
        base_done = done_cnt;
        base_wr = wr_cnt;
        base_acc = rd_acc;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (rd_acc - base_acc < 12 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_mac", 64'(rd_acc - base_acc >= 12), 64'd1);
        srstn = 1'b1;
        @(negedge clk);
        check("abort_en_rd_wr", 64'({bus.dram_en_rd, bus.dram_en_wr}), 64'd0);
        check("abort_busy_done_err", 64'({bus.busy, bus.done, bus.err}), 64'd0);
        check("abort_addr_in", 64'(bus.addr_in), 64'd0);
        check("abort_addr_data_out", 64'({bus.addr_out, bus.data_out}), 64'd0);
        repeat (3) @(negedge clk);
        srstn = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - base_done), 64'd0);
        check("abort_no_write", 64'(wr_cnt - base_wr), 64'd0);
        for (int i = 0; i < 4; i++) expect_wr(32'h300 + i, 32'h0009_0000);
        run_conv("t1_after_abort", cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
